// File: rtl/fifo_wr_feeder.sv
// rtl/fifo_wr_feeder.sv - write-side skid feeder for the dual-clock FIFO with burst/gap pacing and stats
// Two-entry queue; head register drives the FIFO directly, writes are paced by burst/gap and guarded by FIFO flags.
module fifo_wr_feeder #(
    parameter int SIZE      = 8,
    parameter int BURST_LEN = 9,
    parameter int GAP_CYC   = 2
) (
    input  logic            w_clk,
    input  logic            n_rst,
    input  logic            src_valid,
    output logic            src_ready,
    input  logic [SIZE-1:0] src_data,
    input  logic            f_flag,
    input  logic            almost_full_flag,
    output logic [SIZE-1:0] wr_data,
    output logic            valid_write,
    output logic            busy,
    output logic [15:0]     wr_count,
    output logic [15:0]     stall_count
);

    typedef enum logic {
        RUN = 1'b0,
        GAP = 1'b1
    } state_t;

    localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);
    localparam logic       GAP_EN     = (GAP_CYC > 0);
    localparam logic [7:0] GAP_LOAD   = GAP_EN ? 8'(GAP_CYC - 1) : 8'd0;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      count;
    logic [1:0]      count_nxt;
    logic [SIZE-1:0] head_q;
    logic [SIZE-1:0] tail_q;
    logic [7:0]      burst_cnt;
    logic [7:0]      burst_cnt_nxt;
    logic [7:0]      gap_cnt;
    logic [7:0]      gap_cnt_nxt;
    logic            wrote_last;
    logic            can_write;
    logic            accept;
    logic            write;
    logic            stall;

    // Flags lag our writes by a cycle, so after one-free-slot only a write not directly following another is safe.
    assign can_write   = !f_flag && !(almost_full_flag && wrote_last);
    assign write       = (count != 2'd0) && (state == RUN) && can_write;
    assign valid_write = write;
    assign src_ready   = (count < 2'd2);
    assign accept      = src_valid && src_ready;
    assign busy        = (count != 2'd0);
    assign wr_data     = head_q;
    assign stall       = (state == RUN) && (count != 2'd0) && !can_write;
    assign count_nxt   = count + {1'b0, accept} - {1'b0, write};

    always_ff @(posedge w_clk or negedge n_rst) begin
        if (!n_rst) begin
            count  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            count <= count_nxt;
            case ({accept, write})
                2'b10: begin
                    if (count == 2'd0) head_q <= src_data;
                    else               tail_q <= src_data;
                end
                2'b01: begin
                    if (count == 2'd2) head_q <= tail_q;
                end
                // Only reachable with count==1: the incoming word replaces the departing head.
                2'b11: head_q <= src_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= RUN;
            burst_cnt  <= 8'd0;
            gap_cnt    <= 8'd0;
            wrote_last <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst_cnt  <= burst_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
            wrote_last <= write;
        end
    end

    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        gap_cnt_nxt   = gap_cnt;
        case (state)
            RUN: begin
                if (write) begin
                    if (burst_cnt == BURST_LAST) begin
                        burst_cnt_nxt = 8'd0;
                        if (GAP_EN) begin
                            gap_cnt_nxt = GAP_LOAD;
                            state_nxt   = GAP;
                        end
                    end else begin
                        burst_cnt_nxt = burst_cnt + 8'd1;
                    end
                end else begin
                    burst_cnt_nxt = 8'd0;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt   = RUN;
                else                 gap_cnt_nxt = gap_cnt - 8'd1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge w_clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_count    <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            if (write) wr_count <= wr_count + 16'd1;
            if (stall && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_feeder.sv
// tb/tb_fifo_wr_feeder.sv - self-checking bench for fifo_wr_feeder against a queue-based reference model
module tb_fifo_wr_feeder;
    localparam int SIZE = 8;
    localparam int BURST_LEN = 9;
    localparam int GAP_CYC = 2;

    logic w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    logic n_rst = 1'b0;
    logic src_valid = 1'b0, f_flag = 1'b0, almost_full_flag = 1'b0;
    logic [SIZE-1:0] src_data = '0;
    logic src_ready, valid_write, busy;
    logic [SIZE-1:0] wr_data;
    logic [15:0] wr_count, stall_count;

    logic src_valid_b = 1'b0;
    logic [SIZE-1:0] src_data_b = '0;
    logic src_ready_b, valid_write_b, busy_b;
    logic [SIZE-1:0] wr_data_b;
    logic [15:0] wr_count_b, stall_count_b;

    fifo_wr_feeder #(.SIZE(SIZE), .BURST_LEN(BURST_LEN), .GAP_CYC(GAP_CYC)) dut (
        .w_clk(w_clk), .n_rst(n_rst), .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .f_flag(f_flag), .almost_full_flag(almost_full_flag),
        .wr_data(wr_data), .valid_write(valid_write), .busy(busy),
        .wr_count(wr_count), .stall_count(stall_count));

    fifo_wr_feeder #(.SIZE(SIZE), .BURST_LEN(BURST_LEN), .GAP_CYC(0)) dut_b (
        .w_clk(w_clk), .n_rst(n_rst), .src_valid(src_valid_b), .src_ready(src_ready_b),
        .src_data(src_data_b), .f_flag(1'b0), .almost_full_flag(1'b0),
        .wr_data(wr_data_b), .valid_write(valid_write_b), .busy(busy_b),
        .wr_count(wr_count_b), .stall_count(stall_count_b));

    int vectors = 0;
    int miscompares = 0;

    logic [SIZE-1:0] mq[$];
    int m_gap_left, m_run;
    bit m_wrote_last;
    logic [15:0] m_wr, m_stall;
    bit exp_ready, exp_vw, exp_can;
    logic [SIZE-1:0] exp_data;

    function automatic void model_reset();
        mq.delete();
        m_gap_left = 0; m_run = 0; m_wrote_last = 1'b0;
        m_wr = 16'd0; m_stall = 16'd0;
    endfunction

    function automatic void model_eval();
        exp_can   = !f_flag && !(almost_full_flag && m_wrote_last);
        exp_ready = mq.size() < 2;
        exp_vw    = (mq.size() > 0) && (m_gap_left == 0) && exp_can;
        exp_data  = (mq.size() > 0) ? mq[0] : '0;
    endfunction

    function automatic void model_commit();
        bit acc;
        acc = src_valid && exp_ready;
        if (m_gap_left == 0 && mq.size() > 0 && !exp_can && m_stall != 16'hFFFF) m_stall++;
        if (exp_vw) begin
            void'(mq.pop_front());
            m_wr++;
            m_run++;
            if (m_run == BURST_LEN) begin
                m_run = 0;
                m_gap_left = GAP_CYC;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else begin
            m_run = 0;
        end
        if (acc) mq.push_back(src_data);
        m_wrote_last = exp_vw;
    endfunction

    task automatic drive(input bit v, input logic [SIZE-1:0] d, input bit f, input bit af);
        @(negedge w_clk);
        src_valid = v; src_data = d; f_flag = f; almost_full_flag = af;
        #1 model_eval();
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        n_rst = 1'b0; src_valid = 1'b0; f_flag = 1'b0; almost_full_flag = 1'b0; src_data = '0;
        src_valid_b = 1'b0;
        repeat (2) @(negedge w_clk);
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        n_rst = 1'b0; src_valid = 1'b1; src_data = 8'hA5; f_flag = 1'b0; almost_full_flag = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge w_clk); #1;
            vectors++; if (src_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", src_ready); end
            vectors++; if (valid_write !== 1'b0) begin miscompares++; $display("FAIL reset_vw: got %b expected 0", valid_write); end
            vectors++; if (wr_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", wr_data); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
            vectors++; if (wr_count !== 16'd0) begin miscompares++; $display("FAIL reset_wr_count: got %h expected 0", wr_count); end
            vectors++; if (stall_count !== 16'd0) begin miscompares++; $display("FAIL reset_stall_count: got %h expected 0", stall_count); end
        end
        @(negedge w_clk);
        n_rst = 1'b1; src_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_burst_gap();
        int raw[10] = '{21, 503, 90, 10, 20, 820, 30, 1, 55, 23};
        bit pat[14] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0};
        int idx = 0;
        int wi = 0;
        logic [SIZE-1:0] want;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            drive(idx < 10, (idx < 10) ? SIZE'(raw[idx]) : '0, 1'b0, 1'b0);
            vectors++; if (valid_write !== pat[c]) begin miscompares++; $display("FAIL burst_vw[%0d]: got %b expected %b", c, valid_write, pat[c]); end
            if (pat[c]) begin
                want = SIZE'(raw[wi] % 256);
                vectors++; if (wr_data !== want) begin miscompares++; $display("FAIL burst_data[%0d]: got %0d expected %0d", wi, wr_data, want); end
                wi++;
            end
            if (src_valid && src_ready) idx++;
        end
        vectors++; if (wr_count !== 16'd10) begin miscompares++; $display("FAIL burst_wr_count: got %0d expected 10", wr_count); end
    endtask

    task automatic test_backpressure();
        logic [SIZE-1:0] w0, w1;
        w0 = SIZE'($urandom); w1 = SIZE'($urandom);
        do_reset();
        drive(1'b1, w0, 1'b0, 1'b0);
        vectors++; if (valid_write !== 1'b0) begin miscompares++; $display("FAIL bp_first_vw: got %b expected 0", valid_write); end
        for (int k = 1; k <= 5; k++) begin
            drive(k == 1, w1, 1'b1, 1'b0);
            vectors++; if (valid_write !== 1'b0) begin miscompares++; $display("FAIL bp_vw[%0d]: got %b expected 0", k, valid_write); end
            if (k >= 2) begin
                vectors++; if (src_ready !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 0", k, src_ready); end
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (stall_count !== 16'd5) begin miscompares++; $display("FAIL bp_stall_count: got %0d expected 5", stall_count); end
        vectors++; if (valid_write !== 1'b1 || wr_data !== w0) begin miscompares++; $display("FAIL bp_word0: got vw=%b data=%h expected vw=1 data=%h", valid_write, wr_data, w0); end
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (valid_write !== 1'b1 || wr_data !== w1) begin miscompares++; $display("FAIL bp_word1: got vw=%b data=%h expected vw=1 data=%h", valid_write, wr_data, w1); end
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (busy !== 1'b0 || wr_count !== 16'd2 || stall_count !== 16'd5) begin miscompares++; $display("FAIL bp_final: got busy=%b wr=%0d stall=%0d expected 0/2/5", busy, wr_count, stall_count); end
    endtask

    task automatic test_almost_full();
        logic [SIZE-1:0] a, b, c;
        a = SIZE'($urandom); b = SIZE'($urandom); c = SIZE'($urandom);
        do_reset();
        drive(1'b1, a, 1'b0, 1'b0);
        drive(1'b1, b, 1'b0, 1'b0);
        vectors++; if (valid_write !== 1'b1 || wr_data !== a) begin miscompares++; $display("FAIL af_write_a: got vw=%b data=%h expected vw=1 data=%h", valid_write, wr_data, a); end
        drive(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (valid_write !== 1'b0) begin miscompares++; $display("FAIL af_blocked_after_write: got %b expected 0", valid_write); end
        drive(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (valid_write !== 1'b1 || wr_data !== b) begin miscompares++; $display("FAIL af_one_more: got vw=%b data=%h expected vw=1 data=%h", valid_write, wr_data, b); end
        drive(1'b1, c, 1'b1, 1'b1);
        vectors++; if (valid_write !== 1'b0 || src_ready !== 1'b1) begin miscompares++; $display("FAIL af_full: got vw=%b ready=%b expected 0/1", valid_write, src_ready); end
        drive(1'b0, '0, 1'b0, 1'b1);
        vectors++; if (valid_write !== 1'b1 || wr_data !== c) begin miscompares++; $display("FAIL af_idle_then_write: got vw=%b data=%h expected vw=1 data=%h", valid_write, wr_data, c); end
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (stall_count !== 16'd1 || wr_count !== 16'd3) begin miscompares++; $display("FAIL af_counts: got stall=%0d wr=%0d expected 1/3", stall_count, wr_count); end
    endtask

    task automatic test_reset_mid_gap();
        do_reset();
        for (int c = 0; c < 11; c++) drive(1'b1, SIZE'($urandom), 1'b0, 1'b0);
        drive(1'b1, SIZE'($urandom), 1'b0, 1'b0);
        vectors++; if (src_ready !== 1'b0 || valid_write !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL gap_full: got ready=%b vw=%b busy=%b expected 0/0/1", src_ready, valid_write, busy); end
        #1 n_rst = 1'b0;
        #1;
        vectors++; if (src_ready !== 1'b1 || valid_write !== 1'b0 || busy !== 1'b0 || wr_data !== '0) begin miscompares++; $display("FAIL gap_async_reset: got ready=%b vw=%b busy=%b data=%h expected 1/0/0/0", src_ready, valid_write, busy, wr_data); end
        vectors++; if (wr_count !== 16'd0) begin miscompares++; $display("FAIL gap_async_wr_count: got %0d expected 0", wr_count); end
        @(negedge w_clk);
        n_rst = 1'b1; src_valid = 1'b0;
        model_reset();
        for (int c = 0; c < 12; c++) begin
            drive(c < 10, SIZE'($urandom), 1'b0, 1'b0);
            vectors++; if (valid_write !== exp_vw) begin miscompares++; $display("FAIL post_reset_vw[%0d]: got %b expected %b", c, valid_write, exp_vw); end
            vectors++; if (exp_vw && wr_data !== exp_data) begin miscompares++; $display("FAIL post_reset_data[%0d]: got %h expected %h", c, wr_data, exp_data); end
            model_commit();
        end
    endtask

    task automatic test_random(input int n, input int pv, input int pf, input int paf);
        do_reset();
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 99) < pv, SIZE'($urandom), $urandom_range(0, 99) < pf, $urandom_range(0, 99) < paf);
            vectors++; if (src_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, src_ready, exp_ready); end
            vectors++; if (valid_write !== exp_vw) begin miscompares++; $display("FAIL rnd_vw[%0d]: got %b expected %b", i, valid_write, exp_vw); end
            if (exp_vw) begin
                vectors++; if (wr_data !== exp_data) begin miscompares++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, wr_data, exp_data); end
            end
            vectors++; if (busy !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_busy[%0d]: got %b expected %b", i, busy, mq.size() > 0); end
            vectors++; if (wr_count !== m_wr) begin miscompares++; $display("FAIL rnd_wr_count[%0d]: got %0d expected %0d", i, wr_count, m_wr); end
            vectors++; if (stall_count !== m_stall) begin miscompares++; $display("FAIL rnd_stall_count[%0d]: got %0d expected %0d", i, stall_count, m_stall); end
            model_commit();
        end
    endtask

    task automatic test_wrap_saturate();
        logic [SIZE-1:0] held;
        logic [15:0] exp_w;
        held = SIZE'($urandom);
        do_reset();
        for (int i = 0; i <= 65540; i++) begin
            @(negedge w_clk);
            src_valid = (i == 0); src_data = held; f_flag = 1'b1; almost_full_flag = 1'b0;
            src_valid_b = 1'b1; src_data_b = SIZE'(i);
            #1;
            exp_w = 16'(i - 1);
            if (i == 1000 || i == 65535 || i == 65536 || i == 65537 || i == 65538) begin
                vectors++; if (wr_count_b !== exp_w) begin miscompares++; $display("FAIL wrap_wr_count[%0d]: got %h expected %h", i, wr_count_b, exp_w); end
            end
            if (i == 1000 || i == 65535) begin
                vectors++; if (stall_count !== exp_w) begin miscompares++; $display("FAIL sat_stall_count[%0d]: got %h expected %h", i, stall_count, exp_w); end
            end
            if (i == 65536 || i == 65540) begin
                vectors++; if (stall_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_stall_hold[%0d]: got %h expected ffff", i, stall_count); end
                vectors++; if (valid_write !== 1'b0) begin miscompares++; $display("FAIL sat_vw[%0d]: got %b expected 0", i, valid_write); end
            end
        end
        src_valid_b = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (valid_write !== 1'b1 || wr_data !== held) begin miscompares++; $display("FAIL sat_release: got vw=%b data=%h expected vw=1 data=%h", valid_write, wr_data, held); end
        drive(1'b0, '0, 1'b0, 1'b0);
        vectors++; if (wr_count !== 16'd1 || stall_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_final: got wr=%0d stall=%h expected 1/ffff", wr_count, stall_count); end
    endtask

    initial begin
        test_reset();
        test_burst_gap();
        test_backpressure();
        test_almost_full();
        test_reset_mid_gap();
        test_random(1500, 80, 5, 10);
        test_random(1500, 60, 30, 30);
        test_random(1500, 95, 10, 60);
        test_wrap_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
